xbee_tx_sequencer: RTL
======================

Name: xbee_tx_sequencer

Overview:
Controller that sequences the byte-to-serial frame encoder in the XBee transmit path and shares it between two byte sources.
- Arbitrates two requesters round-robin and latches the granted byte.
- Drives the encoder's 3-bit state code and generates its one-cycle baud tick.
- Waits for the encoder's frame-complete flag, then enforces an inter-frame idle gap.
- Flags a timeout if the encoder never reports completion.

Parameters:
TICK_DIV, 5208, clock cycles per baud tick (50 MHz / 9600); legal range 2..65535.
GAP_TICKS, 2, idle baud periods inserted after each frame; legal range 0..255.
TIMEOUT_TICKS, 15, ticks issued in SEND without EncRepeat before the frame is aborted.

Ports:
Clk  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
Enable  in  1  allows new grants; does not abort an in-flight frame.
Req0  in  1  requester 0 has a byte; held with Data0 stable until Ack0.
Data0  in  8  requester 0 byte.
Ack0  out  1  one-cycle pulse: Data0 latched.
Req1  in  1  requester 1 has a byte.
Data1  in  8  requester 1 byte.
Ack1  out  1  one-cycle pulse: Data1 latched.
EncState  out  3  encoder state code: 001 encode, 011 push, 100 move, 111 idle.
EncDin  out  8  byte presented to the encoder.
TickTack  out  1  one-cycle baud tick to the encoder.
EncRepeat  in  1  encoder frame-complete flag.
Busy  out  1  high whenever the FSM is not in IDLE.
FrameDone  out  1  one-cycle pulse when a frame completes.
Error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - Outputs: EncState=111, EncDin=0, TickTack=0, Ack0=Ack1=0, Busy=0, FrameDone=0, Error=0.
  - Internal: FSM=IDLE, all counters 0, last_grant=1, so requester 0 wins the first tie.
- IDLE (EncState=111):
  - Requests are sampled only in IDLE, only when Enable=1.
  - Grant rules: only one Req high -> grant it. Both high -> grant the index != last_grant.
  - On the grant edge: EncDin<=DataN, AckN<=1 for exactly one cycle, last_grant<=N, FSM<=LOAD.
- LOAD: EncState=001 for exactly 2 cycles. The second cycle lets the encoder's registered parity use the newly latched byte. Then PUSH.
- PUSH: EncState=011 for 1 cycle, then SEND.
- SEND (EncState=100):
  - A 16-bit baud counter clears on entry and counts 0..TICK_DIV-1.
  - TickTack=1 in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0. The first tick occurs TICK_DIV cycles after entry.
  - Tick counter (4-bit) increments per tick.
  - EncRepeat=1 sampled -> FrameDone pulse, FSM<=GAP, TickTack=0 that cycle onward.
  - Tick count reaches TIMEOUT_TICKS with EncRepeat still 0 -> Error pulse, FSM<=IDLE (no gap).
  - EncRepeat has priority if both occur in the same cycle.
- GAP: EncState=111, TickTack=0. Hold GAP_TICKS*TICK_DIV cycles; GAP_TICKS=0 -> exactly 1 cycle. Then IDLE.
- Enable deasserted outside IDLE: current frame and gap complete normally; no new grant until Enable=1.
- EncRepeat is ignored outside SEND.
- Req changes outside IDLE are ignored; requests are never queued.
- Ack0 and Ack1 are never high together.
- EncDin is stable from grant until FSM returns to IDLE.
- Busy = (FSM != IDLE), registered with the FSM.
- Back-to-back throughput per frame: 1 + 2 + 1 + (SEND duration) + GAP cycles.

Test Plan:
- Single send (TICK_DIV=4, GAP_TICKS=2, encoder model asserts EncRepeat after 13 ticks), Req0=1, Data0=0xA5:
  - Ack0 high 1 cycle, EncDin=0xA5.
  - EncState sequence 001,001,011, then 100.
  - TickTack pulses every 4th cycle.
  - FrameDone 1 cycle after EncRepeat, then EncState=111 for 8 cycles, then Busy=0.
- Contention, Req0 and Req1 held high from reset, Data0=0x11, Data1=0x22: grants alternate 0x11, 0x22, 0x11, 0x22; Ack pulses alternate.
- Timeout, encoder model never asserts EncRepeat: Error pulses 1 cycle after the 15th tick, FSM returns to IDLE with no gap, EncState=111, FrameDone never pulses.
- Enable gating:
  - Enable=0 with Req1=1 for 20 cycles -> no Ack, Busy=0.
  - Enable->1 -> Ack1 on the next edge.
  - Enable->0 during SEND -> frame and gap complete and FrameDone pulses.
- Asynchronous reset asserted mid-SEND between clock edges: EncState=111, TickTack=0, Busy=0 immediately. After release, a new Req0 is granted normally with requester 0 priority.
- Divider boundary, TICK_DIV=2, GAP_TICKS=0: ticks on every 2nd cycle; gap lasts exactly 1 cycle; the next grant happens the cycle after re-entering IDLE.

Source files
------------

// File: rtl/xbee_tx_sequencer.sv
// rtl/xbee_tx_sequencer.sv - round-robin byte arbiter and baud sequencer for the XBee frame encoder
module xbee_tx_sequencer #(
    parameter int TICK_DIV      = 5208,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Req0,
    input  logic [7:0] Data0,
    output logic       Ack0,
    input  logic       Req1,
    input  logic [7:0] Data1,
    output logic       Ack1,
    output logic [2:0] EncState,
    output logic [7:0] EncDin,
    output logic       TickTack,
    input  logic       EncRepeat,
    output logic       Busy,
    output logic       FrameDone,
    output logic       Error
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PUSH = 3'd2,
        SEND = 3'd3,
        GAP  = 3'd4
    } state_t;

    // A zero-length gap still costs one cycle so IDLE is never re-entered straight from SEND.
    localparam int          GAP_CYCLES = (GAP_TICKS == 0) ? 1 : GAP_TICKS * TICK_DIV;
    localparam logic [15:0] BAUD_LAST  = 16'(TICK_DIV - 1);
    localparam logic [3:0]  TICK_LAST  = 4'(TIMEOUT_TICKS - 1);
    localparam logic [23:0] GAP_LAST   = 24'(GAP_CYCLES - 1);

    state_t      state;
    state_t      nextState;
    logic [15:0] baudCnt;
    logic [3:0]  tickCnt;
    logic [23:0] gapCnt;
    logic        loadSecond;
    logic        lastGrant;

    logic        grant;
    logic        grantIdx;
    logic        tick;
    logic        frameEnd;
    logic        timeout;

    // Arbitration and SEND-phase events decoded from the current state and counters.
    always_comb begin
        grant    = (state == IDLE) && Enable && (Req0 || Req1);
        grantIdx = (Req0 && Req1) ? ~lastGrant : Req1;
        frameEnd = (state == SEND) && EncRepeat;
        tick     = (state == SEND) && (baudCnt == BAUD_LAST) && !EncRepeat;
        timeout  = tick && (tickCnt == TICK_LAST);
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state selection and the state-decoded encoder controls.
    always_comb begin
        nextState = state;
        EncState  = 3'b111;
        TickTack  = 1'b0;
        Busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant) nextState = LOAD;
            end
            LOAD: begin
                EncState = 3'b001;
                if (loadSecond) nextState = PUSH;
            end
            PUSH: begin
                EncState  = 3'b011;
                nextState = SEND;
            end
            SEND: begin
                EncState = 3'b100;
                TickTack = tick;
                if (frameEnd) begin
                    nextState = GAP;
                end else if (timeout) begin
                    nextState = IDLE;
                end
            end
            GAP: begin
                if (gapCnt == GAP_LAST) nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Phase counters; each one sits at zero outside its own state so entry always starts clean.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            loadSecond <= 1'b0;
            baudCnt    <= 16'd0;
            tickCnt    <= 4'd0;
            gapCnt     <= 24'd0;
        end else begin
            loadSecond <= (state == LOAD) && !loadSecond;
            if (state != SEND || baudCnt == BAUD_LAST) begin
                baudCnt <= 16'd0;
            end else begin
                baudCnt <= baudCnt + 16'd1;
            end
            if (state != SEND) begin
                tickCnt <= 4'd0;
            end else if (tick) begin
                tickCnt <= tickCnt + 4'd1;
            end
            if (state != GAP) begin
                gapCnt <= 24'd0;
            end else begin
                gapCnt <= gapCnt + 24'd1;
            end
        end
    end

    // Grant capture plus the one-cycle handshake and status pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Ack0      <= 1'b0;
            Ack1      <= 1'b0;
            EncDin    <= 8'd0;
            lastGrant <= 1'b1;
            FrameDone <= 1'b0;
            Error     <= 1'b0;
        end else begin
            Ack0      <= grant && !grantIdx;
            Ack1      <= grant && grantIdx;
            FrameDone <= frameEnd;
            Error     <= timeout;
            if (grant) begin
                EncDin    <= grantIdx ? Data1 : Data0;
                lastGrant <= grantIdx;
            end
        end
    end

endmodule
